// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Hazard-source inputs and stall/flush controls of the
//                pipeline hazard sequencer, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources from ID / EX / MEM
    logic [3:0]       id_p0_addr;
    logic [3:0]       id_p1_addr;
    logic             id_p0_used;
    logic             id_p1_used;
    logic             ex_mem_re;
    logic             ex_we;
    logic [3:0]       ex_dst_addr;
    logic             ex_mispredict;
    logic             ex_send;
    logic             send_full;
    logic             mem_req;
    logic             mem_rdy;

    // Per-stage controls and status
    logic             pc_hold;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             stall_id_ex;
    logic             flush_id_ex;
    logic             stall_ex_mem;
    logic             stall_mem_wb;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: drives hazard sources, receives controls
    modport master (
        output id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
               ex_mem_re, ex_we, ex_dst_addr, ex_mispredict,
               ex_send, send_full, mem_req, mem_rdy,
        input  pc_hold, stall_if_id, flush_if_id, stall_id_ex,
               flush_id_ex, stall_ex_mem, stall_mem_wb,
               mem_err, stall_cycles
    );

    // Sequencer side: receives hazard sources, drives controls
    modport slave (
        input  id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
               ex_mem_re, ex_we, ex_dst_addr, ex_mispredict,
               ex_send, send_full, mem_req, mem_rdy,
        output pc_hold, stall_if_id, flush_if_id, stall_id_ex,
               flush_id_ex, stall_ex_mem, stall_mem_wb,
               mem_err, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Prioritises watchdog halt, memory wait, SPART send wait,
//                branch mispredict and load-use into per-stage controls.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,   // legal 2..255
    parameter int CNT_W       = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pipe_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [7:0] c_WDOG_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wdog;
    logic [7:0]       w_wdog_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_memw;
    logic             w_sendw;
    logic             w_lu;
    logic             w_p0_match;
    logic             w_p1_match;

    logic             w_pc_hold;
    logic             w_stall_if_id;
    logic             w_flush_if_id;
    logic             w_stall_id_ex;
    logic             w_flush_id_ex;
    logic             w_stall_ex_mem;
    logic             w_stall_mem_wb;

    // Hazard detection terms; R0 is deliberately not special-cased
    always_comb begin
        w_p0_match = bus.id_p0_used && (bus.id_p0_addr == bus.ex_dst_addr);
        w_p1_match = bus.id_p1_used && (bus.id_p1_addr == bus.ex_dst_addr);
        w_lu       = bus.ex_mem_re && bus.ex_we && (w_p0_match || w_p1_match);
        w_sendw    = bus.ex_send && bus.send_full;
        w_memw     = ((r_state == S_RUN) && bus.mem_req && !bus.mem_rdy) ||
                     ((r_state == S_MEM_WAIT) && !bus.mem_rdy);
    end

    // State, watchdog and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_wdog    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wdog    <= w_wdog_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    // Next-state: enter wait on an unfinished access, halt when watchdog expires
    always_comb begin
        w_state_nxt   = r_state;
        w_wdog_nxt    = r_wdog;
        w_mem_err_nxt = r_mem_err;
        case (r_state)
            S_RUN: begin
                if (bus.mem_req && !bus.mem_rdy) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_wdog_nxt  = 8'd1;
                end
            end
            S_MEM_WAIT: begin
                if (bus.mem_rdy) begin
                    w_state_nxt = S_RUN;
                    w_wdog_nxt  = 8'd0;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_state_nxt   = S_HALT;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog + 8'd1;
                end
            end
            S_HALT: begin
                w_mem_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wdog_nxt  = 8'd0;
            end
        endcase
    end

    // Priority encode the hazards into stage controls; reset forces all low
    always_comb begin
        w_pc_hold      = 1'b0;
        w_stall_if_id  = 1'b0;
        w_flush_if_id  = 1'b0;
        w_stall_id_ex  = 1'b0;
        w_flush_id_ex  = 1'b0;
        w_stall_ex_mem = 1'b0;
        w_stall_mem_wb = 1'b0;
        if (rst) begin
            w_pc_hold = 1'b0;
        end else if ((r_state == S_HALT) || w_memw) begin
            // Whole pipeline frozen, MEM/WB fed a bubble
            w_pc_hold      = 1'b1;
            w_stall_if_id  = 1'b1;
            w_stall_id_ex  = 1'b1;
            w_stall_ex_mem = 1'b1;
            w_stall_mem_wb = 1'b1;
        end else if (w_sendw) begin
            // Send sits in ID/EX; EX/MEM keeps draining, mispredict deferred
            w_pc_hold     = 1'b1;
            w_stall_if_id = 1'b1;
            w_stall_id_ex = 1'b1;
        end else if (bus.ex_mispredict) begin
            // PC takes redirect; wrong-path IF and ID contents dropped
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (w_lu) begin
            // Hold the consumer one cycle and insert a single bubble
            w_pc_hold     = 1'b1;
            w_stall_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_hold      = w_pc_hold;
    assign bus.stall_if_id  = w_stall_if_id;
    assign bus.flush_if_id  = w_flush_if_id;
    assign bus.stall_id_ex  = w_stall_id_ex;
    assign bus.flush_id_ex  = w_flush_id_ex;
    assign bus.stall_ex_mem = w_stall_ex_mem;
    assign bus.stall_mem_wb = w_stall_mem_wb;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl
//                (MEM_TIMEOUT=4, CNT_W=4) with an expected-value queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // Control vector order:
    // {pc_hold, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, stall_mem_wb}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_MP   = 7'b0010100;
    localparam logic [6:0] C_SEND = 7'b1101000;
    localparam logic [6:0] C_MEM  = 7'b1101011;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cnt = 4'd0;

    logic [6:0] q_ctl [$];
    logic       q_err [$];
    logic [3:0] q_cnt [$];
    string      q_tag [$];

    task automatic push_exp(input logic [6:0] c, input logic e, input logic [3:0] n, input string tag);
        q_ctl.push_back(c);
        q_err.push_back(e);
        q_cnt.push_back(n);
        q_tag.push_back(tag);
    endtask

    task automatic pop_check();
        logic [6:0] c;
        logic [6:0] obs;
        logic       e;
        logic [3:0] n;
        string      tag;
        c   = q_ctl.pop_front();
        e   = q_err.pop_front();
        n   = q_cnt.pop_front();
        tag = q_tag.pop_front();
        obs = {bus.pc_hold, bus.stall_if_id, bus.flush_if_id, bus.stall_id_ex,
               bus.flush_id_ex, bus.stall_ex_mem, bus.stall_mem_wb};
        checks++;
        assert (obs === c) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, c);
        end
        checks++;
        assert (bus.mem_err === e) else begin
            errors++;
            $error("FAIL %s mem_err observed=%b expected=%b", tag, bus.mem_err, e);
        end
        checks++;
        assert (bus.stall_cycles === n) else begin
            errors++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, bus.stall_cycles, n);
        end
    endtask

    task automatic expect_now(input logic [6:0] c, input logic e, input logic [3:0] n, input string tag);
        push_exp(c, e, n, tag);
        pop_check();
    endtask

    task automatic drive(input logic [3:0] p0a, input logic [3:0] p1a, input logic [3:0] dst,
                         input logic p0u, input logic p1u, input logic lre, input logic we,
                         input logic mp, input logic snd, input logic full,
                         input logic req, input logic rdy);
        bus.id_p0_addr    = p0a;
        bus.id_p1_addr    = p1a;
        bus.ex_dst_addr   = dst;
        bus.id_p0_used    = p0u;
        bus.id_p1_used    = p1u;
        bus.ex_mem_re     = lre;
        bus.ex_we         = we;
        bus.ex_mispredict = mp;
        bus.ex_send       = snd;
        bus.send_full     = full;
        bus.mem_req       = req;
        bus.mem_rdy       = rdy;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance counter model after the edge
    task automatic step(input logic [3:0] p0a, input logic [3:0] p1a, input logic [3:0] dst,
                        input logic p0u, input logic p1u, input logic lre, input logic we,
                        input logic mp, input logic snd, input logic full,
                        input logic req, input logic rdy,
                        input logic [6:0] ec, input logic ee, input string tag);
        drive(p0a, p1a, dst, p0u, p1u, lre, we, mp, snd, full, req, rdy);
        push_exp(ec, ee, exp_cnt, tag);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
        if (ec[6] && (exp_cnt != 4'hF)) exp_cnt = exp_cnt + 4'd1;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_now(C_NONE, 1'b0, 4'd0, "reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "idle");
        // load-use on p1, r3
        step(4'd0, 4'd3, 4'd3, 0, 1, 1, 1, 0, 0, 0, 0, 0, C_LU,   1'b0, "lu_p1");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "post_lu");
        // R0 destination still a hazard
        step(4'd0, 4'd0, 4'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0, C_LU,   1'b0, "lu_r0");
        step(4'd0, 4'd5, 4'd5, 0, 0, 1, 1, 0, 0, 0, 0, 0, C_NONE, 1'b0, "lu_unused");
        step(4'd5, 4'd0, 4'd5, 1, 0, 0, 1, 0, 0, 0, 0, 0, C_NONE, 1'b0, "ex_not_load");
        step(4'd4, 4'd6, 4'd5, 1, 1, 1, 1, 0, 0, 0, 0, 0, C_NONE, 1'b0, "lu_nomatch");
        // mispredict overrides load-use
        step(4'd0, 4'd3, 4'd3, 0, 1, 1, 1, 1, 0, 0, 0, 0, C_MP,   1'b0, "mp_over_lu");

        // memory access ready after three stalled cycles
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1'b0, "mem_req");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MEM,  1'b0, "mem_wait1");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MEM,  1'b0, "mem_wait2");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 1'b0, "mem_rdy");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "mem_back_run");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 1'b0, "mem_single");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "after_single");

        // send held five cycles with pending mispredict, flush on release
        for (int i = 0; i < 5; i++)
            step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0, C_SEND, 1'b0, "send_hold");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0, C_MP,   1'b0, "send_release_mp");

        // memory wait outranks send wait
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 1, 1, 0, C_MEM,  1'b0, "mem_over_send");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 1, 0, 1, C_SEND, 1'b0, "send_after_rdy");

        // push the 4-bit counter into saturation
        for (int i = 0; i < 6; i++)
            step(4'd2, 4'd0, 4'd2, 1, 0, 1, 1, 0, 0, 0, 0, 0, C_LU, 1'b0, "lu_sat");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "sat_hold");

        // watchdog expiry: four stalled cycles then HALT
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1'b0, "wd_req");
        for (int i = 0; i < 3; i++)
            step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MEM, 1'b0, "wd_wait");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_MEM,  1'b1, "halt_rdy");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MEM,  1'b1, "halt_idle");

        // asynchronous reset out of HALT
        rst = 1'b1;
        #1;
        exp_cnt = 4'd0;
        expect_now(C_NONE, 1'b0, 4'd0, "rst_halt");
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "post_rst_halt");

        // asynchronous reset in the middle of MEM_WAIT
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1'b0, "mw_enter");
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        expect_now(C_MEM, 1'b0, exp_cnt, "mw_before_rst");
        #1;
        rst = 1'b1;
        #1;
        exp_cnt = 4'd0;
        expect_now(C_NONE, 1'b0, 4'd0, "rst_mw");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 1'b0, "post_rst_single");
        step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1'b0, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
